output_serializer: RTL
======================

Name: output_serializer

Overview:
- Parametrised successor to the single-word output wrapper.
- Buffers up to DEPTH signed results from the datapath in a small FIFO.
- Arbitrates for the shared narrow output bus with a req/gnt handshake.
- Serialises each DATA_W-bit word onto the BUS_W-bit bus in ceil(DATA_W/BUS_W) beats, in a selectable byte order; beats stall whenever the grant is withdrawn.

Parameters:
- DATA_W, 16: width of each result word.
- BUS_W, 8: width of the output bus.
- DEPTH, 4: FIFO depth in words; must be at least 1.
- MSB_FIRST, 0: 0 sends the least-significant beat first; 1 sends the most-significant beat first.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- data_in, input, DATA_W: signed result word.
- ready, input, 1: write strobe; data_in is sampled on every clk edge where it is 1.
- getdata, input, 1: consumer asks for the next word.
- gnt, input, 1: bus grant from the arbiter.
- req, output, 1: bus request.
- sin_ready, output, 1: a word is available and the block is idle.
- outputbus, output, BUS_W: serial data beat.
- bus_valid, output, 1: outputbus carries a valid beat this cycle.
- full, output, 1: FIFO holds DEPTH words.
- overflow, output, 1: sticky flag, set when a write is dropped.

Behaviour:
- Derived constants: BEATS = ceil(DATA_W/BUS_W); beat index width = clog2(BEATS), minimum 1; FIFO count width = clog2(DEPTH+1).
- Beat k carries bits [k*BUS_W +: BUS_W] of the head word. Bits above DATA_W-1 are zero-padded, not sign-extended.
- Send order: MSB_FIRST=0 sends k = 0..BEATS-1; MSB_FIRST=1 sends k = BEATS-1..0.
- Reset (asynchronous, immediate): FSM goes to IDLE; FIFO is emptied (pointers and count = 0); beat counter = 0; overflow = 0. Outputs req, sin_ready, bus_valid and full go to 0, and outputbus goes to 0. Any in-flight word is discarded.
- FIFO push: on a clk edge with ready=1, if count<DEPTH or a pop happens in the same cycle, data_in is written at the tail. Otherwise the word is dropped and overflow is set to 1 until reset.
- FIFO pop: occurs on the edge that completes the last beat of a word.
- Simultaneous push and pop: both take effect and count is unchanged. This applies at full too, so a full FIFO can accept a new word on the same edge it pops one.
- full = (count == DEPTH), combinational from count.
- FSM state IDLE:
  - sin_ready = (count != 0); req = 0; bus_valid = 0.
  - If count != 0 and getdata = 1, go to REQ; otherwise stay in IDLE.
- FSM state REQ:
  - req = 1.
  - If gnt = 1, go to SEND and reset the beat counter to the first beat; otherwise stay in REQ.
- FSM state SEND:
  - req = 1; bus_valid = gnt.
  - outputbus = current beat of the head word while gnt = 1, else 0.
  - On an edge with gnt = 1: advance the beat counter. If this was the last beat, pop the FIFO, clear the beat counter and go to IDLE.
  - On an edge with gnt = 0: hold state and beat (stall).
- Latency:
  - ready to sin_ready: 1 cycle from an empty, idle block.
  - getdata to req: 1 cycle.
  - gnt in REQ to first beat: 1 cycle.
  - A full word takes BEATS granted cycles.
- outputbus is combinational from state, beat and FIFO head. It is 0 whenever bus_valid = 0.
- getdata is ignored outside IDLE. A word cannot be requested while the FIFO is empty.
- Back-to-back transfers: after the last beat the FSM returns to IDLE for at least 1 cycle, so req deasserts for 1 cycle between words.

Test Plan:
1. DATA_W=16, BUS_W=8, MSB_FIRST=0. Push 16'h7D74, then getdata=1, gnt=1. Expect: req=1 on the cycle after getdata; beats 8'h74 then 8'h7D with bus_valid=1; then IDLE, with sin_ready=0 and count=0.
2. Same word with MSB_FIRST=1. Expect beats 8'h7D then 8'h74.
3. DATA_W=17, BUS_W=8. Push 17'h1_4444. Expect BEATS=3 and beats 8'h44, 8'h44, 8'h01 (zero-padded).
4. DEPTH=4. Push 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005 with no pops. Expect full=1 after the fourth push and overflow=1 after the fifth. Draining returns 0001 through 0004, with 0005 absent. Then push 16'h0006 while full on the final-beat edge of a pop: it is accepted and count stays 4.
5. During SEND, drop gnt for 3 cycles after beat 0. Expect bus_valid=0, outputbus=0 and req held at 1. When gnt returns, beat 1 resumes with the correct byte and no beat is repeated or skipped.
6. Assert rst mid-SEND with 2 words queued. Expect req, bus_valid, full, sin_ready and overflow to go to 0 immediately, with no further beats. After release, a new push of 16'h4444 serialises normally as 8'h44, 8'h44.

Source files
------------

// File: rtl/output_serializer.sv
// output_serializer: buffers signed result words in a small FIFO, requests the
// shared narrow output bus with a req/gnt handshake, and serialises each word
// onto the bus in BEATS beats. A beat stalls whenever the grant is withdrawn.
module output_serializer #(
  parameter int DATA_W    = 16,
  parameter int BUS_W     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     ready,
  input  logic                     getdata,
  input  logic                     gnt,
  output logic                     req,
  output logic                     sin_ready,
  output logic [BUS_W-1:0]         outputbus,
  output logic                     bus_valid,
  output logic                     full,
  output logic                     overflow
);

  localparam int BEATS  = (DATA_W + BUS_W - 1) / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAD_W  = BEATS * BUS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic              overflow_reg;

  logic              last_beat;
  logic              push;
  logic              pop;
  logic [PAD_W-1:0]  head_padded;
  logic [BUS_W-1:0]  beat_data [BEATS];
  logic [BEAT_W-1:0] beat_sel;

  // A word leaves the FIFO on the granted edge that carries its last beat; a
  // write is accepted when there is room or when that pop frees a slot.
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
  assign pop       = (state_reg == SEND) && gnt && last_beat;
  assign push      = ready && ((count_reg != CNT_W'(DEPTH)) || pop);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign overflow  = overflow_reg;

  // FIFO storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // FIFO pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      if (ready && !push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Head word zero-padded up to a whole number of beats, then split into beats.
  always_comb begin
    head_padded               = '0;
    head_padded[DATA_W-1:0]   = mem[rd_ptr_reg];
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_data[gi] = head_padded[gi*BUS_W +: BUS_W];
    end
  endgenerate

  // The beat counter runs in send order; map it to a beat position here.
  assign beat_sel = (MSB_FIRST != 0) ? (BEAT_W'(BEATS - 1) - beat_reg) : beat_reg;

  // Beat counter: restarts on grant in REQ, advances on every granted SEND edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_reg <= '0;
    end else begin
      case (state_reg)
        REQ:     if (gnt) beat_reg <= '0;
        SEND:    if (gnt) beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
        default: beat_reg <= '0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; getdata only matters in IDLE with a word queued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if ((count_reg != '0) && getdata) state_next = REQ;
      REQ:     if (gnt) state_next = SEND;
      SEND:    if (gnt && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; the bus is driven only on granted SEND cycles and is 0 otherwise.
  always_comb begin
    req       = 1'b0;
    sin_ready = 1'b0;
    bus_valid = 1'b0;
    outputbus = '0;
    case (state_reg)
      IDLE: sin_ready = (count_reg != '0);
      REQ:  req = 1'b1;
      SEND: begin
        req       = 1'b1;
        bus_valid = gnt;
        if (gnt) begin
          outputbus = beat_data[beat_sel];
        end
      end
      default: ;
    endcase
  end

endmodule
